// File: rtl/imem_pkg.sv
// Shared definitions for the loadable instruction memory: fill word, FSM encoding
// and the byte-address legality check used by both the fetch and load paths.
package imem_pkg;

  localparam logic [31:0] NOP_WORD = 32'h00000013;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    LOAD  = 2'd2
  } state_t;

  // Word aligned and inside the array.
  function automatic logic addr_legal(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < depth);
  endfunction

endpackage

// File: rtl/imem_ram_1r1w.sv
// DEPTH x 32 storage with one synchronous read port and one synchronous write port.
// The read register only updates when rd_en is high, so rd_data holds between reads.
module imem_ram_1r1w #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned IDX_W = 8
) (
  input  logic             clk,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_data
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/imem_sync_loadable.sv
// Synchronous instruction memory with a 1-cycle fetch port, a runtime program-load
// port and a NOP fill of the whole array after every reset.
module imem_sync_loadable
  import imem_pkg::*;
#(
  parameter int unsigned  DEPTH    = 256,
  parameter logic [31:0]  NOP_WORD = imem_pkg::NOP_WORD,
  localparam int unsigned IDX_W    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fetch_req,
  input  logic [31:0]      fetch_addr,
  output logic [31:0]      fetch_rdata,
  output logic             fetch_valid,
  output logic             fetch_fault,
  output logic             fetch_stall,
  input  logic             ld_en,
  input  logic             ld_valid,
  input  logic [31:0]      ld_addr,
  input  logic [31:0]      ld_data,
  output logic             ld_ready,
  output logic             ld_err,
  output logic [IDX_W:0]   ld_count,
  output state_t           dbg_state
);

  localparam logic [IDX_W:0]   COUNT_MAX = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q;
  logic             fetch_accept, fetch_legal, ld_fire, ld_legal;
  logic             rdata_nop_q;
  logic [31:0]      ram_rdata;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [31:0]      wr_data;

  // Handshakes: a fetch is taken on any edge where fetch_req is high in RUN (including
  // the cycle ld_en rises) and answered on the next edge; a load write is taken on an
  // edge where ld_valid & ld_ready, with ld_ready high for the whole LOAD state.
  assign fetch_accept = fetch_req & (state_q == RUN);
  assign fetch_legal  = addr_legal(fetch_addr, DEPTH);
  assign ld_ready     = (state_q == LOAD);
  assign ld_fire      = ld_valid & ld_ready;
  assign ld_legal     = addr_legal(ld_addr, DEPTH);
  assign fetch_stall  = (state_q != RUN) | ld_en;
  assign dbg_state    = state_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CLEAR:   if (clr_idx_q == LAST_IDX) state_d = RUN;
      RUN:     if (ld_en) state_d = LOAD;
      LOAD:    if (!ld_en) state_d = RUN;
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = clr_idx_q;
    wr_data = NOP_WORD;
    if (state_q == CLEAR) begin
      wr_en = 1'b1;
    end else if (state_q == LOAD) begin
      wr_en   = ld_fire & ld_legal;
      wr_idx  = ld_addr[IDX_W+1:2];
      wr_data = ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == CLEAR) begin
        clr_idx_q <= clr_idx_q + 1'b1;
      end
    end
  end

  // rdata_nop_q selects the fill word after reset and after a faulting fetch, and like
  // the RAM read register it only moves on an accepted fetch, so fetch_rdata holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_valid <= 1'b0;
      fetch_fault <= 1'b0;
      rdata_nop_q <= 1'b1;
    end else begin
      fetch_valid <= fetch_accept;
      fetch_fault <= fetch_accept & ~fetch_legal;
      if (fetch_accept) begin
        rdata_nop_q <= ~fetch_legal;
      end
    end
  end

  assign fetch_rdata = rdata_nop_q ? NOP_WORD : ram_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_count <= '0;
      ld_err   <= 1'b0;
    end else if ((state_q == RUN) && ld_en) begin
      ld_count <= '0;
      ld_err   <= 1'b0;
    end else if (ld_fire) begin
      if (!ld_legal) begin
        ld_err <= 1'b1;
      end else if (ld_count != COUNT_MAX) begin
        ld_count <= ld_count + 1'b1;
      end
    end
  end

  imem_ram_1r1w #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk     (clk),
    .rd_en   (fetch_accept & fetch_legal),
    .rd_idx  (fetch_addr[IDX_W+1:2]),
    .rd_data (ram_rdata),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (wr_data)
  );

endmodule
